ika2151_bus_writer: RTL and testbench

// - Upstream host-side write sequencer for IKA2151. Accepts {register address, data} write requests through a

---
 rtl/ika2151_bus_writer.sv | 191 +++++++++++++++++++
 tb/tb_ika2151_bus_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ika2151_bus_writer.sv
// ika2151_bus_writer
// Host-side write sequencer for the IKA2151. Each {address, data} request is
// queued in a small FIFO. It is then replayed on the chip CPU bus as an
// address write (A0=0) followed by a data write (A0=1). A fixed busy wait
// follows every data write.
//
// Ports
//   i_EMUCLK      master clock, all logic on posedge
//   i_RST         asynchronous active-high reset
//   i_REQ_VALID   write request valid
//   o_REQ_READY   FIFO not full
//   i_REQ_ADDR    OPM register address
//   i_REQ_DATA    OPM register data
//   o_CS_n        chip select to IKA2151
//   o_WR_n        write strobe to IKA2151
//   o_A0          0 = address write, 1 = data write
//   o_D           bus data
//   o_BUSY        sequencer active or requests pending
//   o_FIFO_LEVEL  occupied FIFO entries
module ika2151_bus_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETUP_CYC  = 15,
   parameter int PULSE_CYC  = 20,
   parameter int GAP_CYC    = 15,
   parameter int BUSY_CYC   = 256,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             i_EMUCLK,
   input  logic             i_RST,
   input  logic             i_REQ_VALID,
   output logic             o_REQ_READY,
   input  logic [7:0]       i_REQ_ADDR,
   input  logic [7:0]       i_REQ_DATA,
   output logic             o_CS_n,
   output logic             o_WR_n,
   output logic             o_A0,
   output logic [7:0]       o_D,
   output logic             o_BUSY,
   output logic [LVL_W-1:0] o_FIFO_LEVEL
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_GB  = (GAP_CYC > BUSY_CYC) ? GAP_CYC : BUSY_CYC;
   localparam int CNT_MAX = (MAX_SP > MAX_GB) ? MAX_SP : MAX_GB;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);
   localparam logic [CNT_W-1:0] BUSY_LD  = CNT_W'(BUSY_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADR_SETUP,
      ST_ADR_PULSE,
      ST_ADR_GAP,
      ST_DAT_SETUP,
      ST_DAT_PULSE,
      ST_DAT_GAP,
      ST_BUSY_WAIT
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              pop;
   logic              push;

   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level;
   logic [7:0]        addr_q, data_q;

   assign o_REQ_READY  = (level != LVL_W'(FIFO_DEPTH));
   assign push         = i_REQ_VALID & o_REQ_READY;
   assign o_FIFO_LEVEL = level;
   assign o_BUSY       = (state != ST_IDLE) | (|level);

   // Request FIFO control; pointers wrap naturally because depth is a power of 2
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage and the popped-entry holding registers carry no reset: they are
   // only ever read after a push/pop has written them.
   always_ff @(posedge i_EMUCLK) begin
      if (push) fifo_mem[wr_ptr] <= {i_REQ_ADDR, i_REQ_DATA};
   end

   always_ff @(posedge i_EMUCLK) begin
      if (pop) {addr_q, data_q} <= fifo_mem[rd_ptr];
   end

   // FSM state and shared down-counter
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Each timed state lasts exactly its load value: the counter is loaded on
   // entry and the state is left on the edge where it reads 1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      if (state != ST_IDLE) cnt_nxt = cnt - CNT_ONE;
      case (state)
         ST_IDLE: begin
            if (|level) begin
               pop       = 1'b1;
               state_nxt = ST_ADR_SETUP;
               cnt_nxt   = SETUP_LD;
            end
         end
         ST_ADR_SETUP: if (cnt == CNT_ONE) begin state_nxt = ST_ADR_PULSE; cnt_nxt = PULSE_LD; end
         ST_ADR_PULSE: if (cnt == CNT_ONE) begin state_nxt = ST_ADR_GAP;   cnt_nxt = GAP_LD;   end
         ST_ADR_GAP:   if (cnt == CNT_ONE) begin state_nxt = ST_DAT_SETUP; cnt_nxt = SETUP_LD; end
         ST_DAT_SETUP: if (cnt == CNT_ONE) begin state_nxt = ST_DAT_PULSE; cnt_nxt = PULSE_LD; end
         ST_DAT_PULSE: if (cnt == CNT_ONE) begin state_nxt = ST_DAT_GAP;   cnt_nxt = GAP_LD;   end
         ST_DAT_GAP: begin
            if (cnt == CNT_ONE) begin
               if (BUSY_CYC == 0) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = ST_BUSY_WAIT;
                  cnt_nxt   = BUSY_LD;
               end
            end
         end
         ST_BUSY_WAIT: if (cnt == CNT_ONE) begin state_nxt = ST_IDLE; cnt_nxt = '0; end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Bus outputs are registered from the current state. They therefore trail
   // the state by one edge. A0/D are loaded only on the setup state.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         o_CS_n <= 1'b1;
         o_WR_n <= 1'b1;
         o_A0   <= 1'b0;
         o_D    <= '0;
      end else begin
         case (state)
            ST_ADR_SETUP: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b1;
               o_A0   <= 1'b0;
               o_D    <= addr_q;
            end
            ST_DAT_SETUP: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b1;
               o_A0   <= 1'b1;
               o_D    <= data_q;
            end
            ST_ADR_PULSE, ST_DAT_PULSE: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b0;
            end
            default: begin
               o_CS_n <= 1'b1;
               o_WR_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ika2151_bus_writer.sv
// Testbench for ika2151_bus_writer. A transaction-level reference model
// predicts every output on every cycle. The model is built from the request
// queue, the pop timing and the per-request bus waveform.
module tb_ika2151_bus_writer;

   localparam int DEPTH = 4;
   localparam int S = 15, P = 20, G = 15, B = 256;
   localparam int W = S + P + G;
   localparam int T = 2 * W + B;

   logic       clk = 1'b0;
   logic       rst;
   logic       vld;
   logic [7:0] addr, data;
   logic       ready, cs_n, wr_n, a0, busy;
   logic [7:0] d;
   logic [2:0] level;

   always #5 clk = ~clk;

   ika2151_bus_writer #(
      .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G), .BUSY_CYC(B)
   ) dut (
      .i_EMUCLK(clk), .i_RST(rst), .i_REQ_VALID(vld), .o_REQ_READY(ready),
      .i_REQ_ADDR(addr), .i_REQ_DATA(data), .o_CS_n(cs_n), .o_WR_n(wr_n),
      .o_A0(a0), .o_D(d), .o_BUSY(busy), .o_FIFO_LEVEL(level)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] q[$];
   int          e;
   bit          tx_valid;
   int          ts;
   logic [7:0]  tx_addr, tx_data;
   logic        prev_a0;
   logic [7:0]  prev_d;

   function automatic void model_reset();
      q.delete();
      e        = 0;
      tx_valid = 0;
      ts       = 0;
      prev_a0  = 1'b0;
      prev_d   = 8'h00;
   endfunction

   // A request may start once the previous one has used its full bus
   // occupancy plus one idle cycle.
   function automatic bit engine_free(input int edge_n);
      return !tx_valid || (edge_n >= ts + T + 1);
   endfunction

   function automatic void model_edge();
      int qlen0;
      logic [15:0] ent;
      qlen0 = q.size();
      e++;
      if (qlen0 > 0 && engine_free(e)) begin
         ent = q.pop_front();
         if (tx_valid) begin
            prev_a0 = 1'b1;
            prev_d  = tx_data;
         end
         tx_valid = 1;
         ts = e;
         {tx_addr, tx_data} = ent;
      end
      if (vld && qlen0 < DEPTH) q.push_back({addr, data});
   endfunction

   function automatic logic [15:0] exp_vec();
      logic       ecs, ewr, ea0, ebusy, erdy;
      logic [7:0] ed;
      int         k, sub;
      ecs = 1'b1; ewr = 1'b1; ea0 = prev_a0; ed = prev_d;
      k = e - ts - 1;
      if (tx_valid && k >= 0) begin
         if (k < 2 * W) begin
            ea0 = (k >= W);
            ed  = (k >= W) ? tx_data : tx_addr;
            sub = (k >= W) ? k - W : k;
            if (sub < S + P) ecs = 1'b0;
            if (sub >= S && sub < S + P) ewr = 1'b0;
         end else begin
            ea0 = 1'b1;
            ed  = tx_data;
         end
      end
      ebusy = (q.size() > 0) || (tx_valid && e < ts + T);
      erdy  = (q.size() < DEPTH);
      return {ecs, ewr, ea0, ed, ebusy, erdy, 3'(q.size())};
   endfunction

   // ---------------- per-cycle driver/checker ----------------
   string       phase = "reset";
   logic [8:0]  pulse_log[$];
   logic        last_wr = 1'b1;

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      chk({"cyc_", phase}, 32'({cs_n, wr_n, a0, d, busy, ready, level}), 32'(exp_vec()));
      if (last_wr && !wr_n) pulse_log.push_back({a0, d});
      last_wr = wr_n;
   endtask

   task automatic push_one(input logic [7:0] ad, input logic [7:0] da);
      vld = 1'b1; addr = ad; data = da;
      tick();
      vld = 1'b0;
   endtask

   initial begin
      int cs_adr, wr_adr, wr_dat, busy_cnt, guard, pct;
      rst = 1'b1; vld = 1'b0; addr = 8'h00; data = 8'h00;
      model_reset();
      repeat (5) tick();
      rst = 1'b0;

      // single request
      phase = "single";
      cs_adr = 0; wr_adr = 0; wr_dat = 0; busy_cnt = 0;
      push_one(8'h18, 8'hFF);
      busy_cnt += busy;
      repeat (T + 10) begin
         tick();
         if (!cs_n && !a0) cs_adr++;
         if (!wr_n && !a0) wr_adr++;
         if (!wr_n && a0)  wr_dat++;
         busy_cnt += busy;
      end
      chk("adr_cs_low_cycles", 32'(cs_adr), 32'(S + P));
      chk("adr_wr_low_cycles", 32'(wr_adr), 32'(P));
      chk("dat_wr_low_cycles", 32'(wr_dat), 32'(P));
      chk("busy_cycles", 32'(busy_cnt), 32'(T + 1));

      // back-to-back pair
      phase = "pair";
      pulse_log.delete();
      push_one(8'h18, 8'hFF);
      push_one(8'h1B, 8'h02);
      repeat (2 * T + 10) tick();
      chk("pulse_count", 32'(pulse_log.size()), 32'd4);
      if (pulse_log.size() == 4) begin
         chk("pulse0", 32'(pulse_log[0]), 32'h018);
         chk("pulse1", 32'(pulse_log[1]), 32'h1FF);
         chk("pulse2", 32'(pulse_log[2]), 32'h01B);
         chk("pulse3", 32'(pulse_log[3]), 32'h102);
      end

      // overfill while busy
      phase = "full";
      push_one(8'h20, 8'h01);
      repeat (3) tick();
      for (int i = 0; i < 5; i++) push_one(8'h30 + 8'(i), 8'h40 + 8'(i));
      chk("ready_full", 32'(ready), 32'd0);
      chk("level_full", 32'(level), 32'd4);

      // push on the same edge as a pop at level 1
      phase = "pushpop";
      guard = 0;
      while (!(q.size() == 1 && engine_free(e + 1)) && guard < 3000) begin
         tick();
         guard++;
      end
      chk("pushpop_wait_bound", 32'(guard < 3000), 32'd1);
      push_one(8'h55, 8'hAA);
      chk("level_pushpop", 32'(level), 32'd1);
      repeat (2 * T + 10) tick();

      // reset in the middle of a data pulse, with one request queued
      phase = "midreset";
      push_one(8'h11, 8'h22);
      push_one(8'h33, 8'h44);
      guard = 0;
      while (!(tx_valid && (e - ts - 1) == W + S + 3) && guard < 1000) begin
         tick();
         guard++;
      end
      chk("midreset_wait_bound", 32'(guard < 1000), 32'd1);
      chk("pre_rst_wr_low", 32'(wr_n), 32'd0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_cs_high", 32'(cs_n), 32'd1);
      chk("rst_wr_high", 32'(wr_n), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      pulse_log.delete();
      repeat (400) tick();
      chk("no_strobe_after_rst", 32'(pulse_log.size()), 32'd0);

      // randomized traffic
      phase = "random";
      for (int blk = 0; blk < 30; blk++) begin
         case ($urandom_range(0, 2))
            0:       pct = 1;
            1:       pct = 5;
            default: pct = 40;
         endcase
         repeat (500) begin
            vld  = ($urandom_range(0, 99) < pct);
            addr = 8'($urandom);
            data = 8'($urandom);
            tick();
         end
      end
      vld = 1'b0;
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
